rc4_encrypt_mem: RTL and testbench
==================================

RC4_ENCRYPT_MEM -- requirements
Module: rc4_encrypt_mem

Interface
REQ-001 Parameter MSG_LEN, default 32, sets the number of message bytes processed per run (1..32).
REQ-002 Parameter KEY_BYTES, default 3, sets the number of key bytes cycled in the KSA; it is fixed at 3 in this block.
REQ-003 Port clk, input, 1 bit, is the single clock; every flop samples on its rising edge.
REQ-004 Port reset, input, 1 bit, is the reset; it is asynchronous and active-high.
REQ-005 Port start, input, 1 bit, is a run request sampled in IDLE only.
REQ-006 Port secret_key, input, 24 bits, is the key, captured on start; key byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0].
REQ-007 Ports s_address (out, 8), s_data (out, 8), s_wren (out, 1) and s_q (in, 8) form the S-box RAM port.
REQ-008 Ports pt_address (out, 5) and pt_q (in, 8) form the plaintext RAM read port.
REQ-009 Ports ct_address (out, 5), ct_data (out, 8) and ct_wren (out, 1) form the ciphertext RAM write port.
REQ-010 Port busy, output, 1 bit, is high in every state except IDLE and DONE.
REQ-011 Port done, output, 1 bit, is a one-cycle pulse when a run completes.
REQ-012 Port error, output, 1 bit, is the plaintext-check failure flag (see Configuration).

Function
REQ-013 All RAMs have a registered read: q is valid on the second rising edge after the address is driven, so each read costs one wait state.
REQ-014 The state machine has the states IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR_J, KSA_WR_I, PRGA_RD_I, PRGA_RD_J, PRGA_SWAP, PRGA_RD_F, PRGA_RD_PT, PRGA_WR_CT and DONE; the wait states are internal substates.
REQ-015 In IDLE with start=1, the block latches secret_key, clears i, j and k, and goes to INIT.
REQ-016 INIT writes s[n]=n for n=0..255, one write per cycle with s_wren=1, then goes to KSA with i=0 and j=0.
REQ-017 The KSA runs for i=0..255:
- j = (j + s[i] + key[i mod 3]) mod 256, with all sums truncated to 8 bits.
- s[i] and s[j] are swapped: s[j] is written first, then s[i].
- After i=255 the block moves to PRGA with i=0 and j=0.
REQ-018 The PRGA runs for k=0..MSG_LEN-1:
- i = i+1, then j = j + s[i], then s[i] and s[j] are swapped.
- f = s[(s[i]+s[j]) mod 256].
- ct[k] = f XOR pt[k], written with ct_wren=1 for exactly one cycle.
REQ-019 s_wren is high only during S-box write cycles, and ct_wren is high only in PRGA_WR_CT.
REQ-020 When i=j, the swap writes the same value twice and the S-box is left unchanged.
REQ-021 After the write of k=MSG_LEN-1, the block enters DONE, pulses done for one cycle, and returns to IDLE.
REQ-022 start asserted while busy=1 is ignored, and secret_key changes while busy=1 have no effect on the run.
REQ-023 k wraps nowhere: pt_address and ct_address never exceed MSG_LEN-1.

Reset
REQ-024 reset=1 immediately forces state to IDLE and drives every output to 0: all addresses, s_data, ct_data, both write enables, busy, done and error.
REQ-025 Reset asserted mid-run abandons the run; no further RAM writes occur, and the next start begins again from INIT.

Configuration
REQ-026 Macro RC4_PLAINTEXT_CHECK_EN controls the plaintext check:
- Defined: each pt_q byte that is not 'a'..'z' (97..122) and not space (32) sets error=1 and sends the FSM to DONE without writing that ct byte; done still pulses, and error holds until the next start or reset.
- Not defined: every byte is encrypted and error is tied to 0.

Verification
REQ-027 Reset then start with any key -> s[n]=n for all n at the end of INIT; busy=1 from the cycle after start.
REQ-028 MSG_LEN=9, secret_key=24'h4B6579, pt="Plaintext" with the check disabled -> ct = BB F3 16 E8 D9 40 AF 0A D3, then one done pulse.
REQ-029 Round trip: encrypt 32 lowercase/space bytes with key 24'h000102, reload ct as pt, run again -> the original plaintext is recovered byte-exact.
REQ-030 Reset asserted at KSA i=100 -> all outputs 0 within the same cycle and no ct_wren; a new start with key 24'h4B6579 gives the REQ-028 result.
REQ-031 With RC4_PLAINTEXT_CHECK_EN and pt[5]='A' -> ct[0..4] are written, ct[5] is not, error=1 and done pulses once.
REQ-032 start pulsed during PRGA -> ignored; the ciphertext matches an uninterrupted run.

Source files
------------

// File: rtl/rc4_encrypt_mem.sv
// RC4 encryptor: initialises and key-schedules an external S-box RAM, then encrypts MSG_LEN plaintext bytes.
// Optional macro RC4_PLAINTEXT_CHECK_EN aborts a run on any byte outside 'a'..'z' and space.
module rc4_encrypt_mem #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  output logic [4:0]  pt_address,
  input  logic [7:0]  pt_q,
  output logic [4:0]  ct_address,
  output logic [7:0]  ct_data,
  output logic        ct_wren,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR_J, KSA_WR_I, PRGA_RD_I,
    PRGA_RD_J, PRGA_SWAP, PRGA_RD_F, PRGA_RD_PT, PRGA_WR_CT, DONE
  } state_t;

  state_t      state, state_n;
  logic        wt, wt_n;
  logic [7:0]  i, i_n, j, j_n, si, si_n, sj, sj_n, f, f_n;
  logic [4:0]  k, k_n;
  logic [1:0]  kidx, kidx_n;
  logic [23:0] key, key_n;
  logic [7:0]  s_address_n, s_data_n, ct_data_n;
  logic [4:0]  pt_address_n, ct_address_n;
  logic        s_wren_n, ct_wren_n, busy_n, done_n, error_n;
  logic [7:0]  ksa_j, prga_j;

  function automatic logic [7:0] key_byte(input logic [23:0] kv, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = kv[23:16];
      2'd1:    key_byte = kv[15:8];
      default: key_byte = kv[7:0];
    endcase
  endfunction

`ifdef RC4_PLAINTEXT_CHECK_EN
  function automatic logic pt_ok(input logic [7:0] b);
    pt_ok = ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
  endfunction
`endif

  assign ksa_j  = j + s_q + key_byte(key, kidx);
  assign prga_j = j + s_q;

  // Each RAM read: address presented on entry, wt=0 cycle, wt=1 cycle, q captured leaving wt=1.
  always_comb begin
    state_n = state;  wt_n = 1'b0;  i_n = i;  j_n = j;  k_n = k;  kidx_n = kidx;
    key_n = key;  si_n = si;  sj_n = sj;  f_n = f;
    s_address_n = s_address;  s_data_n = s_data;  s_wren_n = 1'b0;
    pt_address_n = pt_address;  ct_address_n = ct_address;  ct_data_n = ct_data;
    ct_wren_n = 1'b0;  error_n = error;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = INIT;  key_n = secret_key;  i_n = 8'd0;  j_n = 8'd0;  k_n = 5'd0;
          kidx_n = 2'd0;  error_n = 1'b0;
          s_address_n = 8'd0;  s_data_n = 8'd0;  s_wren_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      INIT: begin
        if (i == 8'd255) begin
          state_n = KSA_RD_I;  i_n = 8'd0;  j_n = 8'd0;  s_address_n = 8'd0;
        end else begin
          i_n = i + 8'd1;  s_address_n = i + 8'd1;  s_data_n = i + 8'd1;  s_wren_n = 1'b1;
        end
      end
      KSA_RD_I: begin
        if (!wt) begin
          wt_n = 1'b1;
        end else begin
          si_n = s_q;  j_n = ksa_j;  s_address_n = ksa_j;  state_n = KSA_RD_J;
        end
      end
      KSA_RD_J: begin
        if (!wt) begin
          wt_n = 1'b1;
        end else begin
          sj_n = s_q;  state_n = KSA_WR_J;
          s_address_n = j;  s_data_n = si;  s_wren_n = 1'b1;
        end
      end
      KSA_WR_J: begin
        state_n = KSA_WR_I;  s_address_n = i;  s_data_n = sj;  s_wren_n = 1'b1;
      end
      KSA_WR_I: begin
        if (i == 8'd255) begin
          state_n = PRGA_RD_I;  i_n = 8'd1;  j_n = 8'd0;  s_address_n = 8'd1;
        end else begin
          state_n = KSA_RD_I;  i_n = i + 8'd1;  s_address_n = i + 8'd1;
          kidx_n = (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
        end
      end
      PRGA_RD_I: begin
        if (!wt) begin
          wt_n = 1'b1;
        end else begin
          si_n = s_q;  j_n = prga_j;  s_address_n = prga_j;  state_n = PRGA_RD_J;
        end
      end
      PRGA_RD_J: begin
        if (!wt) begin
          wt_n = 1'b1;
        end else begin
          sj_n = s_q;  state_n = PRGA_SWAP;
          s_address_n = j;  s_data_n = si;  s_wren_n = 1'b1;
        end
      end
      // wt=0: s[j] write in progress, queue s[i]; wt=1: s[i] write in progress, queue the f read.
      PRGA_SWAP: begin
        if (!wt) begin
          wt_n = 1'b1;  s_address_n = i;  s_data_n = sj;  s_wren_n = 1'b1;
        end else begin
          state_n = PRGA_RD_F;  s_address_n = si + sj;
        end
      end
      PRGA_RD_F: begin
        if (!wt) begin
          wt_n = 1'b1;
        end else begin
          f_n = s_q;  pt_address_n = k;  state_n = PRGA_RD_PT;
        end
      end
      PRGA_RD_PT: begin
        if (!wt) begin
          wt_n = 1'b1;
`ifdef RC4_PLAINTEXT_CHECK_EN
        end else if (!pt_ok(pt_q)) begin
          error_n = 1'b1;  state_n = DONE;
`endif
        end else begin
          ct_address_n = k;  ct_data_n = f ^ pt_q;  ct_wren_n = 1'b1;  state_n = PRGA_WR_CT;
        end
      end
      PRGA_WR_CT: begin
        if (k == 5'(MSG_LEN - 1)) begin
          state_n = DONE;
        end else begin
          k_n = k + 5'd1;  i_n = i + 8'd1;  s_address_n = i + 8'd1;  state_n = PRGA_RD_I;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifndef RC4_PLAINTEXT_CHECK_EN
    error_n = 1'b0;
`endif
    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;  wt <= 1'b0;  i <= 8'd0;  j <= 8'd0;  k <= 5'd0;  kidx <= 2'd0;
      key <= 24'd0;  si <= 8'd0;  sj <= 8'd0;  f <= 8'd0;
      s_address <= 8'd0;  s_data <= 8'd0;  s_wren <= 1'b0;  pt_address <= 5'd0;
      ct_address <= 5'd0;  ct_data <= 8'd0;  ct_wren <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;  error <= 1'b0;
    end else begin
      state <= state_n;  wt <= wt_n;  i <= i_n;  j <= j_n;  k <= k_n;  kidx <= kidx_n;
      key <= key_n;  si <= si_n;  sj <= sj_n;  f <= f_n;
      s_address <= s_address_n;  s_data <= s_data_n;  s_wren <= s_wren_n;
      pt_address <= pt_address_n;  ct_address <= ct_address_n;  ct_data <= ct_data_n;
      ct_wren <= ct_wren_n;  busy <= busy_n;  done <= done_n;  error <= error_n;
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_mem.sv
// Scoreboard bench for rc4_encrypt_mem: array-based RC4 reference, RAM models, ct-write monitor.
module tb_rc4_encrypt_mem;
  localparam int ML = 9;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [23:0] secret_key = 24'd0;
  logic [7:0]  s_address, s_data, s_q, pt_q, ct_data;
  logic [4:0]  pt_address, ct_address;
  logic        s_wren, ct_wren, busy, done, error;

  logic [7:0]  smem [256];
  logic [7:0]  ptmem [32];
  logic [7:0]  ctmem [32];
  logic [7:0]  orig [ML];
  logic [7:0]  kv_pt [ML] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0]  kv_ct [ML] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  int          checks = 0, errors = 0, done_cnt = 0, exp_err = 0;
  int          model_s [256];
  logic [12:0] exp_q [$];

  always #5 clk = ~clk;

  rc4_encrypt_mem #(.MSG_LEN(ML), .KEY_BYTES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren),
    .busy(busy), .done(done), .error(error)
  );

  // Registered-read RAMs.
  always @(posedge clk) begin
    if (s_wren) smem[s_address] <= s_data;
    s_q  <= smem[s_address];
    pt_q <= ptmem[pt_address];
    if (ct_wren) ctmem[ct_address] <= ct_data;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] all_out();
    all_out = 64'({s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren, busy, done, error});
  endfunction

  // Reference RC4 straight from the algorithm; pushes every expected ct write.
  task automatic model_run(input logic [23:0] key);
    int s[256];
    int kb[3];
    int i, j, t, f;
    logic [4:0] ka;
    logic [7:0] d;
    kb[0] = int'(key[23:16]);  kb[1] = int'(key[15:8]);  kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n];  s[n] = s[j];  s[j] = t;
    end
    i = 0;  j = 0;  exp_err = 0;
    for (int k = 0; k < ML; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i];  s[i] = s[j];  s[j] = t;
      f = s[(s[i] + s[j]) % 256];
`ifdef RC4_PLAINTEXT_CHECK_EN
      if (!((ptmem[k] >= 8'd97 && ptmem[k] <= 8'd122) || ptmem[k] == 8'd32)) begin
        exp_err = 1;
        break;
      end
`endif
      ka = k[4:0];
      d  = f[7:0] ^ ptmem[k];
      exp_q.push_back({ka, d});
    end
    for (int n = 0; n < 256; n++) model_s[n] = s[n];
  endtask

  task automatic monitor();
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done) done_cnt++;
        if (ct_wren) begin
          chk(exp_q.size() != 0, "ct_write_expected", {ct_address, ct_data}, 64'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({ct_address, ct_data} == e, "ct_write", {ct_address, ct_data}, e);
          end
        end
      end
    end
  endtask

  task automatic fill_lower();
    int r;
    for (int k = 0; k < ML; k++) begin
      r = $urandom_range(0, 26);
      ptmem[k] = (r == 26) ? 8'd32 : 8'(97 + r);
    end
  endtask

  task automatic wait_init_end(output int bad);
    int cyc = 0;
    while (!(busy && !s_wren) && cyc < 400) begin @(negedge clk); cyc++; end
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== 8'(n)) bad++;
  endtask

  task automatic run_one(input logic [23:0] key, input bit inject);
    int cyc, bad;
    model_run(key);
    done_cnt = 0;
    @(negedge clk);  start = 1'b1;  secret_key = key;
    @(negedge clk);  start = 1'b0;  secret_key = 24'($urandom);
    chk(busy == 1'b1, "busy_after_start", 64'(busy), 64'd1);
    wait_init_end(bad);
    chk(bad == 0, "sbox_identity_after_init", 64'(bad), 64'd0);
    if (inject) begin
      repeat (1560) @(negedge clk);
      start = 1'b1;  secret_key = 24'($urandom);
      @(negedge clk);  start = 1'b0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 4000) begin @(negedge clk); cyc++; end
    chk(done === 1'b1, "done_seen", 64'(done), 64'd1);
    chk(busy == 1'b0, "busy_in_done", 64'(busy), 64'd0);
    chk(error == 1'(exp_err), "error_flag", 64'(error), 64'(exp_err));
    repeat (3) @(negedge clk);
    chk(done_cnt == 1, "done_pulse_count", 64'(done_cnt), 64'd1);
    chk(error == 1'(exp_err), "error_hold", 64'(error), 64'(exp_err));
    chk(exp_q.size() == 0, "ct_write_count", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== 8'(model_s[n])) bad++;
    chk(bad == 0, "sbox_final", 64'(bad), 64'd0);
  endtask

  task automatic check_known();
`ifndef RC4_PLAINTEXT_CHECK_EN
    for (int k = 0; k < ML; k++)
      chk(ctmem[k] == kv_ct[k], "known_vector", 64'(ctmem[k]), 64'(kv_ct[k]));
`endif
  endtask

  initial begin
    int bad;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk(all_out() == 64'd0, "reset_outputs", all_out(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk(all_out() == 64'd0, "idle_outputs", all_out(), 64'd0);

    for (int k = 0; k < ML; k++) ptmem[k] = kv_pt[k];
    run_one(24'h4B6579, 1'b0);
    check_known();

    fill_lower();
    for (int k = 0; k < ML; k++) orig[k] = ptmem[k];
    run_one(24'h000102, 1'b0);
    for (int k = 0; k < ML; k++) ptmem[k] = ctmem[k];
    run_one(24'h000102, 1'b0);
`ifndef RC4_PLAINTEXT_CHECK_EN
    for (int k = 0; k < ML; k++)
      chk(ctmem[k] == orig[k], "round_trip", 64'(ctmem[k]), 64'(orig[k]));
`endif

    for (int r = 0; r < 2; r++) begin
      fill_lower();
      run_one(24'($urandom), 1'b1);
    end

`ifdef RC4_PLAINTEXT_CHECK_EN
    fill_lower();
    ptmem[5] = 8'h41;
    run_one(24'($urandom), 1'b0);
    chk(error == 1'b1, "error_after_bad_byte", 64'(error), 64'd1);
`endif

    // Abort during KSA at i=100; any later ct write is unexpected (queue is empty).
    fill_lower();
    @(negedge clk);  start = 1'b1;  secret_key = 24'($urandom);
    @(negedge clk);  start = 1'b0;
    wait_init_end(bad);
    repeat (600) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk(all_out() == 64'd0, "async_reset_outputs", all_out(), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk(all_out() == 64'd0, "idle_after_abort", all_out(), 64'd0);

    for (int k = 0; k < ML; k++) ptmem[k] = kv_pt[k];
    run_one(24'h4B6579, 1'b0);
    check_known();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
